// File: rtl/wb_periph_splitter.sv
// Wishbone classic 1-to-N peripheral splitter with decode-miss and
// slave-timeout error responses plus a saturating error counter.
module wb_periph_splitter #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [7:0]  BASE_HI        = 8'h30,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic [31:0]              wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic [NUM_SLAVES-1:0]    m_cyc_o,
    output logic [NUM_SLAVES-1:0]    m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [32*NUM_SLAVES-1:0] m_dat_i,
    input  logic [NUM_SLAVES-1:0]    m_ack_i,
    output logic                     err_pulse_o,
    output logic [7:0]               err_count_o
);

    localparam int             TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]     NS5   = 5'(NUM_SLAVES);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              slot_q;
    logic [TW-1:0]           tcnt_q;
    logic                    req;
    logic                    hit;
    logic                    abort;
    logic                    tmo;
    logic                    sel_ack;
    logic [31:0]             sel_dat;
    logic [NUM_SLAVES-1:0]   onehot;
    logic [7:0]              cnt_next;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign hit      = (wbs_adr_i[31:24] == BASE_HI) &&
                      ({1'b0, wbs_adr_i[19:16]} < NS5);
    assign abort    = ~wbs_cyc_i;
    assign tmo      = (tcnt_q == TLAST);
    assign cnt_next = (err_count_o == 8'hFF) ? err_count_o
                                             : err_count_o + 8'd1;

    // Per-slot muxing: latched slot for the response path, live address
    // for the select being launched.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        onehot  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (slot_q == 4'(k)) begin
                sel_ack = m_ack_i[k];
                sel_dat = m_dat_i[32*k +: 32];
            end
            if (wbs_adr_i[19:16] == 4'(k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = hit ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sel_ack || tmo) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_dat_o   <= '0;
            wbs_ack_o   <= 1'b0;
            m_cyc_o     <= '0;
            m_stb_o     <= '0;
            m_we_o      <= 1'b0;
            m_sel_o     <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            err_pulse_o <= 1'b0;
            err_count_o <= '0;
            slot_q      <= '0;
            tcnt_q      <= '0;
        end else begin
            wbs_ack_o   <= 1'b0;
            err_pulse_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        m_we_o  <= wbs_we_i;
                        m_sel_o <= wbs_sel_i;
                        m_adr_o <= wbs_adr_i;
                        m_dat_o <= wbs_dat_i;
                        slot_q  <= wbs_adr_i[19:16];
                        tcnt_q  <= '0;
                        if (hit) begin
                            m_cyc_o <= onehot;
                            m_stb_o <= onehot;
                        end else begin
                            wbs_ack_o   <= 1'b1;
                            wbs_dat_o   <= ERR_DATA;
                            err_pulse_o <= 1'b1;
                            err_count_o <= cnt_next;
                        end
                    end
                end
                BUSY: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (abort) begin
                        m_cyc_o <= '0;
                        m_stb_o <= '0;
                    end else if (sel_ack) begin
                        m_cyc_o   <= '0;
                        m_stb_o   <= '0;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= sel_dat;
                    end else if (tmo) begin
                        m_cyc_o     <= '0;
                        m_stb_o     <= '0;
                        wbs_ack_o   <= 1'b1;
                        wbs_dat_o   <= ERR_DATA;
                        err_pulse_o <= 1'b1;
                        err_count_o <= cnt_next;
                    end
                end
                default: begin
                    m_cyc_o <= '0;
                    m_stb_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_periph_splitter.sv
// Directed and randomized checks of wb_periph_splitter against a
// transaction-level model of decode, latency, timeout and error count.
module tb_wb_periph_splitter;

    localparam int          NS   = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   adr = '0;
    logic [31:0]   wdat = '0;
    logic [31:0]   rdat;
    logic          ack;
    logic [NS-1:0] m_cyc;
    logic [NS-1:0] m_stb;
    logic          m_we;
    logic [3:0]    m_sel;
    logic [31:0]   m_adr;
    logic [31:0]   m_dat;
    logic [127:0]  s_dat = '0;
    logic [NS-1:0] s_ack = '0;
    logic          err_pulse;
    logic [7:0]    err_count;

    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    wb_periph_splitter #(
        .NUM_SLAVES(NS),
        .BASE_HI(8'h30),
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA(ERRD)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i(we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_dat_o(rdat),
        .wbs_ack_o(ack),
        .m_cyc_o(m_cyc),
        .m_stb_o(m_stb),
        .m_we_o(m_we),
        .m_sel_o(m_sel),
        .m_adr_o(m_adr),
        .m_dat_o(m_dat),
        .m_dat_i(s_dat),
        .m_ack_i(s_ack),
        .err_pulse_o(err_pulse),
        .err_count_o(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // dly: cycles after the strobe before the slave acks (>= TMO never acks
    // in time). abort_at: cycle index at which the master drops cyc, or -1.
    task automatic run_txn(input logic [31:0] a, input logic w,
                           input logic [3:0] s, input logic [31:0] d_in,
                           input int dly, input logic [31:0] sd,
                           input bit noise, input int abort_at);
        int            slot;
        bit            hit;
        bit            e;
        int            k;
        int            exp_stb;
        int            exp_acks;
        logic [NS-1:0] oh;
        int            stb_cnt = 0;
        int            acks = 0;
        int            pulses = 0;
        int            bad = 0;
        int            ack_c = -1;
        logic [31:0]   ack_dat = '0;
        logic          ack_pl = 1'b0;
        bit            capt = 1'b0;
        logic [31:0]   c_adr = 'x;
        logic [31:0]   c_dat = 'x;
        logic [3:0]    c_sel = 'x;
        logic          c_we = 1'bx;
        logic [127:0]  seg;

        slot = int'(a[19:16]);
        hit  = (a[31:24] == 8'h30) && (slot < NS);
        e    = !hit || (dly >= TMO);
        k    = !hit ? 0 : (e ? TMO : dly + 1);
        oh   = hit ? (NS'(1) << slot) : '0;
        if (abort_at >= 0) begin
            exp_stb  = abort_at + 1;
            exp_acks = 0;
        end else begin
            exp_stb  = k;
            exp_acks = 1;
        end
        if (exp_acks == 1 && e) begin
            model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
        end

        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        sel  = s;
        adr  = a;
        wdat = d_in;

        for (int c = 0; c < TMO + 6; c++) begin
            @(negedge clk);
            if (m_stb != '0) begin
                stb_cnt++;
                if (!capt) begin
                    capt  = 1'b1;
                    c_adr = m_adr;
                    c_dat = m_dat;
                    c_sel = m_sel;
                    c_we  = m_we;
                end
            end
            if ((m_stb & ~oh) != '0) bad++;
            if (m_cyc !== m_stb) bad++;
            if (err_pulse) pulses++;
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    ack_c   = c;
                    ack_dat = rdat;
                    ack_pl  = err_pulse;
                end
            end
            if (ack || c == abort_at) begin
                cyc = 1'b0;
                stb = 1'b0;
                we  = 1'b0;
            end
            s_ack = noise ? NS'($urandom) : '0;
            s_ack = s_ack & ~oh;
            s_dat = {$urandom, $urandom, $urandom, $urandom};
            if (c == dly && (m_stb & oh) != '0) begin
                s_ack = s_ack | oh;
                seg   = {96'b0, 32'hFFFF_FFFF} << (32 * slot);
                s_dat = (s_dat & ~seg) | ({96'b0, sd} << (32 * slot));
            end
        end
        s_ack = '0;

        chk("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
        chk("select_onehot", 32'(bad), 32'd0);
        chk("ack_count", 32'(acks), 32'(exp_acks));
        chk("err_pulses", 32'(pulses), (exp_acks == 1 && e) ? 32'd1 : 32'd0);
        if (exp_acks == 1) begin
            chk("ack_cycle", 32'(ack_c), 32'(k));
            chk("rdata", ack_dat, e ? ERRD : sd);
            chk("pulse_with_ack", 32'(ack_pl), 32'(e));
        end
        if (hit) begin
            chk("m_adr", c_adr, a);
            chk("m_we", 32'(c_we), 32'(w));
            chk("m_sel", 32'(c_sel), 32'(s));
            chk("m_dat", c_dat, d_in);
        end
        chk("err_count", 32'(err_count), 32'(model_cnt));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_rdat"}, rdat, 32'd0);
        chk({tag, "_m_cyc"}, 32'(m_cyc), 32'd0);
        chk({tag, "_m_stb"}, 32'(m_stb), 32'd0);
        chk({tag, "_m_adr"}, m_adr, 32'd0);
        chk({tag, "_m_dat"}, m_dat, 32'd0);
        chk({tag, "_m_ctl"}, {27'd0, m_we, m_sel}, 32'd0);
        chk({tag, "_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          dly;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(32'h3002_0004, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678, 1'b0, -1);
        run_txn(32'h3001_0000, 1'b1, 4'b0011, 32'hA5A5_A5A5, 5,
                32'h0BAD_F00D, 1'b1, -1);
        run_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h1111_1111, 1'b0, -1);
        run_txn(32'h3007_0000, 1'b0, 4'hF, 32'h0, 0, 32'h2222_2222, 1'b0, -1);
        chk("count_after_misses", 32'(err_count), 32'd2);

        run_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 100, 32'h3333_3333, 1'b1, -1);
        run_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 7, 32'h4444_4444, 1'b1, -1);

        run_txn(32'h3003_0008, 1'b1, 4'h1, 32'h5555_5555, 100, 32'h0, 1'b0, 3);
        run_txn(32'h3003_0008, 1'b0, 4'hF, 32'h0, 2, 32'h6666_6666, 1'b0, -1);

        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        sel  = 4'hC;
        adr  = 32'h3001_0040;
        wdat = 32'h7777_7777;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", 32'(m_stb), 32'h2);
        rst_n = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        model_cnt = 0;
        rst_n = 1'b1;
        run_txn(32'h3001_0040, 1'b0, 4'hF, 32'h0, 1, 32'h8888_8888, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[31:24] = 8'h30;
            a[19:16] = 4'($urandom_range(5));
            dly = $urandom_range(10);
            run_txn(a, 1'($urandom), 4'($urandom), $urandom, dly, $urandom,
                    1'($urandom), -1);
        end

        for (int i = 0; i < 260; i++) begin
            run_txn(32'h2000_0000 | 32'($urandom_range(255)), 1'b0, 4'hF,
                    32'h0, 0, 32'h0, 1'b0, -1);
        end
        chk("count_saturated", 32'(err_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
